// File: rtl/sd_credit_pkg.sv
// Link-protocol constants shared by the credit transmitter (sd_credit_tx)
// and receiver (sd_credit_rx).
package sd_credit_pkg;

    localparam int SD_DEPTH_DEFAULT  = 4;
    localparam int SD_DEPTH_MIN      = 2;
    localparam int SD_DEPTH_MAX      = 64;
    localparam int SD_CREDIT_PULSE_W = 1;

endpackage

// File: rtl/sd_credit_rx.sv
// Credit-based link receiver: circular buffer of depth entries, one returned
// credit pulse per consumed entry, sticky overflow on a beat sent without credit.
module sd_credit_rx
    import sd_credit_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = SD_DEPTH_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         c_vld,
    input  logic [width-1:0]             c_data,
    output logic                         c_credit,
    output logic                         p_srdy,
    input  logic                         p_drdy,
    output logic [width-1:0]             p_data,
    output logic [$clog2(depth+1)-1:0]   occupancy,
    output logic                         overflow
);

    localparam int PTR_W = $clog2(depth);
    localparam int OCC_W = $clog2(depth+1);

    logic [width-1:0] mem_q [depth];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             srdy_q, srdy_d;
    logic             credit_q, credit_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, full, accept;

    // Explicit wrap so non-power-of-2 depths never index past depth-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        push     = c_vld;
        pop      = srdy_q && p_drdy;
        full     = (occ_q == OCC_W'(depth));
        accept   = push && (!full || pop);

        wr_d     = accept ? ptr_inc(wr_q) : wr_q;
        rd_d     = pop ? ptr_inc(rd_q) : rd_q;

        occ_d    = occ_q;
        if (accept && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!accept && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end

        srdy_d   = (occ_d != '0);
        credit_d = pop;
        ovf_d    = ovf_q || (push && !accept);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q     <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
            srdy_q   <= 1'b0;
            credit_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            occ_q    <= occ_d;
            srdy_q   <= srdy_d;
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            mem_q[wr_q] <= c_data;
        end
    end

    assign p_data    = mem_q[rd_q];
    assign p_srdy    = srdy_q;
    assign c_credit  = credit_q;
    assign occupancy = occ_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/sd_credit_rx.md
SD_CREDIT_RX -- requirements
Module: sd_credit_rx

Interface
REQ-001 SHALL have parameter width, default 8, meaning data bits per beat.
REQ-002 SHALL have parameter depth, default 4, meaning receive buffer entries and initial credit count at the transmitter; legal range 2..64.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port c_vld, input, 1, link beat valid, no backpressure.
REQ-006 SHALL have port c_data, input, width, link beat data, sampled when c_vld=1.
REQ-007 SHALL have port c_credit, output, 1, one-cycle pulse returning one credit to the transmitter.
REQ-008 SHALL have port p_srdy, output, 1, consumer data valid.
REQ-009 SHALL have port p_drdy, input, 1, consumer ready.
REQ-010 SHALL have port p_data, output, width, head-of-buffer data.
REQ-011 SHALL have port occupancy, output, clog2(depth+1), current stored entry count.
REQ-012 SHALL have port overflow, output, 1, sticky error flag.

Function
REQ-013 SHALL treat push = c_vld and pop = p_srdy && p_drdy.
REQ-014 SHALL store entries in a depth-entry circular buffer with wr_ptr/rd_ptr wrapping from depth-1 to 0, for any depth including non-power-of-2.
REQ-015 SHALL write c_data at wr_ptr and advance wr_ptr on push when occupancy<depth, or when occupancy==depth and pop is asserted in the same cycle.
REQ-016 SHALL, on push with occupancy==depth and no pop, drop the beat, leave buffer and pointers unchanged, and set overflow=1 from the next cycle.
REQ-017 SHALL update occupancy +1 on accepted push only, -1 on pop only, unchanged on both or neither.
REQ-018 SHALL drive p_srdy directly from a flop, equal to (next occupancy != 0).
REQ-019 SHALL drive p_data as the buffer entry at rd_ptr, selected only by flops, with no combinational path from c_vld, c_data or p_drdy.
REQ-020 SHALL have latency of one cycle: push in cycle N into an empty buffer gives p_srdy=1 and p_data=that beat in cycle N+1.
REQ-021 SHALL not forward data combinationally: a push into an empty buffer is not visible in the same cycle.
REQ-022 SHALL assert c_credit from a flop in cycle N+1 for every pop in cycle N, exactly one pulse per pop, with back-to-back pops giving back-to-back pulses.
REQ-023 SHALL not return a credit for a dropped overflow beat.
REQ-024 SHALL preserve order: p_data sequence equals accepted c_data sequence.
REQ-025 SHALL hold p_data stable while p_srdy=1 and p_drdy=0.
REQ-026 SHALL keep overflow at 1 until reset.

Reset
REQ-027 SHALL, with reset=1 at a posedge, set wr_ptr=0, rd_ptr=0, occupancy=0, p_srdy=0, c_credit=0, overflow=0; buffer contents are not reset.
REQ-028 SHALL discard all stored entries on reset mid-operation and return no credits for them; the transmitter resets to depth credits concurrently.
REQ-029 SHALL ignore c_vld and p_drdy in a cycle where reset=1.

Structure
REQ-030 SHALL take the shared link-protocol constants (default depth, credit pulse width = 1) from package sd_credit_pkg, which the transmitter sd_credit_tx also uses.
REQ-031 SHALL implement the buffer, pointers and credit flop inline with no sub-module; sd_credit_tx is a separate peer block, not instantiated here.

Verification
REQ-032 SHALL cover single beat: reset, depth=4, c_vld=1 with c_data=0xA5 in cycle 1 -> p_srdy=1, p_data=0xA5 in cycle 2; p_drdy=1 in cycle 2 -> c_credit=1 in cycle 3 only, occupancy=0.
REQ-033 SHALL cover fill and stall: push 0x01..0x04 with p_drdy=0 -> occupancy=4, p_data=0x01 stable, c_credit=0 throughout.
REQ-034 SHALL cover full with simultaneous push/pop: occupancy=4, push 0x05 with p_drdy=1 -> 0x05 accepted, overflow=0, occupancy=4, c_credit pulse next cycle.
REQ-035 SHALL cover overflow: occupancy=4, p_drdy=0, push 0x06 -> overflow=1 next cycle, 0x06 never appears at p_data, occupancy stays 4.
REQ-036 SHALL cover streaming and wrap: depth=3, 20 beats 0x00..0x13 with p_drdy random -> in-order output, total c_credit pulses=20, pointers wrap cleanly.
REQ-037 SHALL cover reset mid-stream: reset with occupancy=2 -> next cycle p_srdy=0, occupancy=0, overflow=0, no c_credit pulse.
